// File: rtl/keypad_pkg.sv
// Shared key codes, digit limit and press-filter state encoding for the
// keypad number-entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  localparam int unsigned MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    RELEASE
  } press_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// Keypad stream in, BCD entry/commit state out. The scanner side is the
// master; the entry buffer is the slave.
interface keypad_entry_buffer_if;

  logic [3:0]  key_value;
  logic        key_valid;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic [15:0] committed;
  logic        commit_pulse;
  logic        err_pulse;
  logic [15:0] display_value;

  modport master (
    output key_value, key_valid,
    input  entry, digit_count, committed, commit_pulse, err_pulse, display_value
  );

  modport slave (
    input  key_value, key_valid,
    output entry, digit_count, committed, commit_pulse, err_pulse, display_value
  );

endinterface

// File: rtl/keypad_entry_buffer_press_filter.sv
// Press filter: one press_pulse per physical key press, with a release
// debounce of RELEASE_CYCLES consecutive low cycles before the next press.
module key_press_filter
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  output logic       press_pulse,
  output logic [3:0] press_code
);

  localparam int unsigned CNT_W = $clog2(RELEASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

  press_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign press_code = key_value;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          press_pulse = 1'b1;
          state_d     = PRESSED;
        end
      end
      PRESSED: begin
        if (!key_valid) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        // A saturated counter means the low period is already complete, so a
        // press landing on that same edge is a new press, as if from IDLE.
        if (cnt_q == CNT_LAST) begin
          if (key_valid) begin
            press_pulse = 1'b1;
            state_d     = PRESSED;
          end else begin
            state_d = IDLE;
          end
        end else if (key_valid) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Four-digit BCD entry register driven by filtered key presses: digits shift
// in from the right, with backspace, clear and enter/commit editing keys.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 reset_p,
  keypad_entry_buffer_if.slave kp
);

  logic       press_pulse;
  logic [3:0] press_code;

  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] committed_q, committed_d;
  logic        commit_pulse_q, commit_pulse_d;
  logic        err_pulse_q, err_pulse_d;

  key_press_filter #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .reset_p    (reset_p),
    .key_value  (kp.key_value),
    .key_valid  (kp.key_valid),
    .press_pulse(press_pulse),
    .press_code (press_code)
  );

  always_comb begin
    entry_d        = entry_q;
    count_d        = count_q;
    committed_d    = committed_q;
    commit_pulse_d = 1'b0;
    err_pulse_d    = 1'b0;
    if (press_pulse) begin
      if (is_digit(press_code)) begin
        if (count_q < 3'(MAX_DIGITS)) begin
          entry_d = {entry_q[11:0], press_code};
          count_d = count_q + 3'd1;
        end else begin
          err_pulse_d = 1'b1;
        end
      end else begin
        unique case (press_code)
          KEY_BKSP: begin
            if (count_q != '0) begin
              entry_d = {4'h0, entry_q[15:4]};
              count_d = count_q - 3'd1;
            end else begin
              err_pulse_d = 1'b1;
            end
          end
          KEY_CLR: begin
            entry_d = '0;
            count_d = '0;
          end
          KEY_ENTER: begin
            committed_d    = entry_q;
            commit_pulse_d = 1'b1;
            entry_d        = '0;
            count_d        = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      entry_q        <= '0;
      count_q        <= '0;
      committed_q    <= '0;
      commit_pulse_q <= 1'b0;
      err_pulse_q    <= 1'b0;
    end else begin
      entry_q        <= entry_d;
      count_q        <= count_d;
      committed_q    <= committed_d;
      commit_pulse_q <= commit_pulse_d;
      err_pulse_q    <= err_pulse_d;
    end
  end

  assign kp.entry         = entry_q;
  assign kp.digit_count   = count_q;
  assign kp.committed     = committed_q;
  assign kp.commit_pulse  = commit_pulse_q;
  assign kp.err_pulse     = err_pulse_q;
  assign kp.display_value = (count_q != '0) ? entry_q : committed_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer with a 4-cycle release debounce.
module tb_keypad_entry_buffer;

  logic clk = 1'b0;
  logic reset_p;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  keypad_entry_buffer_if kp ();

  keypad_entry_buffer #(
    .RELEASE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .kp     (kp)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] e_entry,
                              input logic [2:0] e_count, input logic [15:0] e_comm,
                              input logic e_cp, input logic e_ep);
    logic [15:0] e_disp;
    e_disp = (e_count != 3'd0) ? e_entry : e_comm;
    chk({tag, ".entry"}, kp.entry, e_entry);
    chk({tag, ".count"}, 16'(kp.digit_count), 16'(e_count));
    chk({tag, ".committed"}, kp.committed, e_comm);
    chk({tag, ".commit_pulse"}, 16'(kp.commit_pulse), 16'(e_cp));
    chk({tag, ".err_pulse"}, 16'(kp.err_pulse), 16'(e_ep));
    chk({tag, ".display"}, kp.display_value, e_disp);
  endtask

  // Accepting edge for a key; outputs are checked right after it.
  task automatic press(input logic [3:0] code);
    kp.key_value = code;
    kp.key_valid = 1'b1;
    step(1);
  endtask

  task automatic rel();
    kp.key_valid = 1'b0;
    step(4);
  endtask

  initial begin
    reset_p      = 1'b1;
    kp.key_value = 4'h0;
    kp.key_valid = 1'b0;
    #2;
    expect_state("reset0", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0);
    step(2);
    reset_p = 1'b0;
    step(1);

    // 1: reset mid-press, held key accepted right after reset release
    press(4'h1); expect_state("t1.d1", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0); rel();
    press(4'h2); expect_state("t1.d2", 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0);
    kp.key_value = 4'h5;
    reset_p = 1'b1;
    #1;
    expect_state("t1.async_rst", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0);
    step(2);
    reset_p = 1'b0;
    step(1);
    expect_state("t1.held5", 16'h0005, 3'd1, 16'h0000, 1'b0, 1'b0);
    rel();

    // 2: clear, then 1 2 3 4 enter
    press(4'hB); expect_state("t2.clr", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0); rel();
    press(4'h1); expect_state("t2.d1", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0); rel();
    press(4'h2); expect_state("t2.d2", 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0); rel();
    press(4'h3); expect_state("t2.d3", 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0); rel();
    press(4'h4); expect_state("t2.d4", 16'h1234, 3'd4, 16'h0000, 1'b0, 1'b0); rel();
    press(4'hE); expect_state("t2.enter", 16'h0000, 3'd0, 16'h1234, 1'b1, 1'b0);
    step(1);     expect_state("t2.pulse_end", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0);
    rel();

    // 3: overflow and backspace underflow
    press(4'h1); rel(); press(4'h2); rel(); press(4'h3); rel(); press(4'h4); rel();
    press(4'h9); expect_state("t3.ovf", 16'h1234, 3'd4, 16'h1234, 1'b0, 1'b1);
    step(1);     expect_state("t3.ovf_end", 16'h1234, 3'd4, 16'h1234, 1'b0, 1'b0);
    rel();
    press(4'hA); expect_state("t3.bk1", 16'h0123, 3'd3, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hA); expect_state("t3.bk2", 16'h0012, 3'd2, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hA); expect_state("t3.bk3", 16'h0001, 3'd1, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hA); expect_state("t3.bk4", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hA); expect_state("t3.bk5", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b1); rel();

    // 4: bounce rejection
    press(4'h7);
    kp.key_valid = 1'b0; step(2);
    kp.key_valid = 1'b1; step(3);
    rel();
    expect_state("t4.bounce", 16'h0007, 3'd1, 16'h1234, 1'b0, 1'b0);
    press(4'hB); rel();

    // 5: spacing, 4 low cycles accepted, 3 low cycles absorbed
    press(4'h3); rel();
    press(4'h3); expect_state("t5.gap4", 16'h0033, 3'd2, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hB); rel();
    press(4'h3);
    kp.key_valid = 1'b0; step(3);
    kp.key_valid = 1'b1; step(1);
    expect_state("t5.gap3", 16'h0003, 3'd1, 16'h1234, 1'b0, 1'b0);
    rel();
    press(4'hB); rel();

    // 6: ignored keys, clear, empty enter
    press(4'h5); rel(); press(4'h6); rel();
    press(4'hC); expect_state("t6.keyC", 16'h0056, 3'd2, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hD); expect_state("t6.keyD", 16'h0056, 3'd2, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hF); expect_state("t6.keyF", 16'h0056, 3'd2, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hB); expect_state("t6.clr", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0); rel();
    press(4'hE); expect_state("t6.enter0", 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b0); rel();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
